// File: rtl/jk_fsm_bank.sv
// jk_fsm_bank: CHANNELS independent OFF/HOLD/ON Moore machines with a minimum
// on-time, selectable j/k conflict priority, registered edge pulses and an active count.
module jk_fsm_bank #(
    parameter int CHANNELS = 4,
    parameter int DWELL    = 3,
    parameter int MODE     = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           j,
    input  logic [CHANNELS-1:0]           k,
    output logic [CHANNELS-1:0]           out,
    output logic [CHANNELS-1:0]           rise,
    output logic [CHANNELS-1:0]           fall,
    output logic [$clog2(CHANNELS+1)-1:0] active_cnt,
    output logic                          all_off
);

    localparam int CW       = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
    localparam int NW       = $clog2(CHANNELS + 1);
    localparam int DWELL_M1 = (DWELL > 0) ? DWELL - 1 : 0;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_LOAD = DWELL_M1[CW-1:0];
    localparam logic          SET_PRIO = (MODE == 1) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_HOLD = 2'd1,
        ST_ON   = 2'd2
    } state_t;

    state_t            state_r [CHANNELS];
    state_t            state_s [CHANNELS];
    logic [CW-1:0]     cnt_r   [CHANNELS];
    logic [CW-1:0]     cnt_s   [CHANNELS];
    logic [CHANNELS-1:0] cur_on_s;
    logic [CHANNELS-1:0] next_on_s;
    logic [CHANNELS-1:0] rise_r;
    logic [CHANNELS-1:0] fall_r;
    logic [NW-1:0]       sum_s;

    // Per-channel state and dwell counter registers
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (reset) begin
                state_r[i] <= ST_OFF;
                cnt_r[i]   <= CNT_ZERO;
            end else begin
                state_r[i] <= state_s[i];
                cnt_r[i]   <= cnt_s[i];
            end
        end
    end

    // Next-state decode: HOLD ignores j/k so out stays high for at least DWELL+1 cycles
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_s[i] = state_r[i];
            cnt_s[i]   = cnt_r[i];
            case (state_r[i])
                ST_OFF: begin
                    if (j[i]) begin
                        if (DWELL > 0) begin
                            state_s[i] = ST_HOLD;
                            cnt_s[i]   = CNT_LOAD;
                        end else begin
                            state_s[i] = ST_ON;
                        end
                    end else begin
                        state_s[i] = ST_OFF;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r[i] == CNT_ZERO) begin
                        state_s[i] = ST_ON;
                    end else begin
                        cnt_s[i] = cnt_r[i] - CNT_ONE;
                    end
                end
                ST_ON: begin
                    if (k[i] && !(j[i] && SET_PRIO)) begin
                        state_s[i] = ST_OFF;
                    end else begin
                        state_s[i] = ST_ON;
                    end
                end
                default: begin
                    state_s[i] = ST_OFF;
                    cnt_s[i]   = CNT_ZERO;
                end
            endcase
        end
    end

    // Output decode: current/next on flags and popcount of the current state
    always_comb begin
        cur_on_s  = {CHANNELS{1'b0}};
        next_on_s = {CHANNELS{1'b0}};
        sum_s     = {NW{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            cur_on_s[i]  = (state_r[i] != ST_OFF);
            next_on_s[i] = (state_s[i] != ST_OFF);
            sum_s        = sum_s + NW'(cur_on_s[i]);
        end
    end

    // Edge pulses registered from the next-state decode so they line up with out
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_r <= {CHANNELS{1'b0}};
            fall_r <= {CHANNELS{1'b0}};
        end else begin
            rise_r <= next_on_s & ~cur_on_s;
            fall_r <= ~next_on_s & cur_on_s;
        end
    end

    assign out        = cur_on_s;
    assign rise       = rise_r;
    assign fall       = fall_r;
    assign active_cnt = sum_s;
    assign all_off    = (sum_s == {NW{1'b0}});

endmodule

// File: tb/tb_jk_fsm_bank.sv
// Bench for jk_fsm_bank: directed vector table plus random traffic against a
// reference model that tracks "on" and remaining forced-on edges per channel.
module tb_jk_fsm_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] j0, k0, j1, k1;
    logic [3:0] out0, rise0, fall0, out1, rise1, fall1;
    logic [2:0] cnt0, cnt1;
    logic       all_off0, all_off1;

    int tests = 0;
    int fails = 0;

    bit m_on   [2][4];
    int m_rem  [2][4];
    bit m_rise [2][4];
    bit m_fall [2][4];

    typedef struct {
        logic       rst;
        logic [3:0] j;
        logic [3:0] k;
        logic [3:0] e_out;
        logic [3:0] e_rise;
        logic [3:0] e_fall;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t tbl [$];

    always #5 clk = ~clk;

    jk_fsm_bank #(.CHANNELS(4), .DWELL(3), .MODE(0)) u0 (
        .clk(clk), .reset(reset), .j(j0), .k(k0), .out(out0), .rise(rise0),
        .fall(fall0), .active_cnt(cnt0), .all_off(all_off0)
    );

    jk_fsm_bank #(.CHANNELS(4), .DWELL(0), .MODE(1)) u1 (
        .clk(clk), .reset(reset), .j(j1), .k(k1), .out(out1), .rise(rise1),
        .fall(fall1), .active_cnt(cnt1), .all_off(all_off1)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A channel that turns on is forced on for `dwell` further edges, then k may clear it.
    task automatic model_step(input int d, input int dwell, input int mode,
                              input logic rst, input logic [3:0] jj, input logic [3:0] kk);
        for (int i = 0; i < 4; i++) begin
            bit prev;
            prev = m_on[d][i];
            if (rst) begin
                m_on[d][i] = 1'b0; m_rem[d][i] = 0; m_rise[d][i] = 1'b0; m_fall[d][i] = 1'b0;
            end else begin
                if (!prev) begin
                    if (jj[i]) begin
                        m_on[d][i] = 1'b1; m_rem[d][i] = dwell;
                    end
                end else if (m_rem[d][i] > 0) begin
                    m_rem[d][i] = m_rem[d][i] - 1;
                end else if (kk[i] && !(jj[i] && mode == 1)) begin
                    m_on[d][i] = 1'b0;
                end
                m_rise[d][i] = m_on[d][i] && !prev;
                m_fall[d][i] = !m_on[d][i] && prev;
            end
        end
    endtask

    task automatic cmp_model(input int d, input logic [3:0] o, input logic [3:0] r,
                             input logic [3:0] f, input logic [2:0] c, input logic ao);
        logic [3:0] eo, er, ef;
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            eo[i] = m_on[d][i]; er[i] = m_rise[d][i]; ef[i] = m_fall[d][i];
            n += int'(m_on[d][i]);
        end
        check($sformatf("u%0d out", d),        {4'd0, o}, {4'd0, eo});
        check($sformatf("u%0d rise", d),       {4'd0, r}, {4'd0, er});
        check($sformatf("u%0d fall", d),       {4'd0, f}, {4'd0, ef});
        check($sformatf("u%0d active_cnt", d), {5'd0, c}, 8'(n));
        check($sformatf("u%0d all_off", d),    {7'd0, ao}, {7'd0, (n == 0)});
        check($sformatf("u%0d rise&fall", d),  {4'd0, r & f}, 8'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0, 3, 0, reset, j0, k0);
        model_step(1, 0, 1, reset, j1, k1);
        @(negedge clk);
        cmp_model(0, out0, rise0, fall0, cnt0, all_off0);
        cmp_model(1, out1, rise1, fall1, cnt1, all_off1);
    endtask

    task automatic add_vec(input logic rst, input logic [3:0] jj, input logic [3:0] kk,
                           input logic [3:0] eo, input logic [3:0] er, input logic [3:0] ef,
                           input logic [2:0] ec);
        vec_t v;
        v.rst = rst; v.j = jj; v.k = kk; v.e_out = eo; v.e_rise = er; v.e_fall = ef; v.e_cnt = ec;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with j asserted, then release with j low
        add_vec(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0);
        add_vec(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0);
        add_vec(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0);
        // dwell: one-cycle j[0], k[0] held
        add_vec(1'b0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 3'd1);
        for (int n = 0; n < 3; n++) add_vec(1'b0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 3'd1);
        add_vec(1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 3'd0);
        add_vec(1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 3'd0);
        // toggle: j[1]=k[1]=1, two periods of 5
        for (int p = 0; p < 2; p++) begin
            add_vec(1'b0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 3'd1);
            for (int n = 0; n < 3; n++) add_vec(1'b0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 3'd1);
            add_vec(1'b0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h2, 3'd0);
        end
        add_vec(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0);
        // aggregate: all on, then release one at a time
        add_vec(1'b0, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 3'd4);
        for (int n = 0; n < 3; n++) add_vec(1'b0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 3'd4);
        add_vec(1'b0, 4'h0, 4'h1, 4'hE, 4'h0, 4'h1, 3'd3);
        add_vec(1'b0, 4'h0, 4'h2, 4'hC, 4'h0, 4'h2, 3'd2);
        add_vec(1'b0, 4'h0, 4'h4, 4'h8, 4'h0, 4'h4, 3'd1);
        add_vec(1'b0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h8, 3'd0);
        // reset mid-HOLD (cnt=1), then a full dwell again
        add_vec(1'b0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 3'd1);
        add_vec(1'b0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 3'd1);
        add_vec(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0);
        add_vec(1'b0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 3'd1);
        for (int n = 0; n < 3; n++) add_vec(1'b0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 3'd1);
        add_vec(1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 3'd0);

        reset = 1'b1; j0 = 4'h0; k0 = 4'h0; j1 = 4'h0; k1 = 4'h0;

        foreach (tbl[idx]) begin
            reset = tbl[idx].rst; j0 = tbl[idx].j; k0 = tbl[idx].k; j1 = 4'h0; k1 = 4'h0;
            step();
            check($sformatf("vec%0d out", idx),  {4'd0, out0},  {4'd0, tbl[idx].e_out});
            check($sformatf("vec%0d rise", idx), {4'd0, rise0}, {4'd0, tbl[idx].e_rise});
            check($sformatf("vec%0d fall", idx), {4'd0, fall0}, {4'd0, tbl[idx].e_fall});
            check($sformatf("vec%0d cnt", idx),  {5'd0, cnt0},  {5'd0, tbl[idx].e_cnt});
            check($sformatf("vec%0d all_off", idx), {7'd0, all_off0},
                  {7'd0, (tbl[idx].e_cnt == 3'd0)});
        end

        // set-priority instance: j=k=1 on ch2 holds ON, dropping j clears it
        reset = 1'b0; j0 = 4'h0; k0 = 4'h0; j1 = 4'h4; k1 = 4'h4;
        step();
        check("setprio on", {4'd0, out1}, 8'h04);
        check("setprio rise", {4'd0, rise1}, 8'h04);
        for (int n = 0; n < 3; n++) begin
            step();
            check("setprio hold", {4'd0, out1}, 8'h04);
            check("setprio nofall", {4'd0, fall1}, 8'h00);
        end
        j1 = 4'h0;
        step();
        check("setprio off", {4'd0, out1}, 8'h00);
        check("setprio fall", {4'd0, fall1}, 8'h04);
        k1 = 4'h0;

        // random traffic on both instances against the model
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            j0 = 4'($urandom); k0 = 4'($urandom);
            j1 = 4'($urandom); k1 = 4'($urandom);
            if ($urandom_range(0, 1) == 1) j0 = j0 & 4'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jk_fsm_bank.md
# jk_fsm_bank

Bank of CHANNELS independent JK-style Moore state machines with a programmable minimum on-time (dwell), a selectable j/k conflict mode, per-channel edge pulses and an aggregate active count. It is the multi-channel successor to the team's single two-state j-sets/k-clears FSM. It sits between raw request/release strobes and downstream consumers that need debounced, minimum-length enables plus status.

## Interface
- CHANNELS, default 4: number of independent channels (>=1).
- DWELL, default 3: minimum cycles spent in HOLD before k is honoured (>=0, < 2^16).
- MODE, default 0: behaviour when j and k are both 1 in ON.
  - 0 = JK: k wins, go OFF.
  - 1 = set-priority: stay ON.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; clock clk.
- j  in  CHANNELS  per-channel set request, sampled at posedge.
- k  in  CHANNELS  per-channel clear request, sampled at posedge.
- out  out  CHANNELS  per-channel Moore output; 1 when the channel state is not OFF.
- rise  out  CHANNELS  registered one-cycle pulse in the first cycle out[i] is 1 after being 0.
- fall  out  CHANNELS  registered one-cycle pulse in the first cycle out[i] is 0 after being 1.
- active_cnt  out  $clog2(CHANNELS+1)  popcount of out, combinational from state.
- all_off  out  1  1 when active_cnt == 0.

## Operation
- Per-channel states: OFF, HOLD, ON. Each channel has a dwell counter of width max(1, $clog2(DWELL+1)).
- OFF, j=0: stay OFF; k is ignored.
- OFF, j=1: if DWELL>0, go HOLD and load cnt = DWELL-1; if DWELL==0, go ON directly.
- HOLD: j and k are ignored.
  - cnt != 0: cnt decrements.
  - cnt == 0: go ON.
- ON:
  - k=0: stay ON.
  - k=1, j=0: go OFF.
  - k=1, j=1: go OFF when MODE=0; stay ON when MODE=1.
- With DWELL=0, MODE=0 and CHANNELS=1, behaviour is cycle-identical to the legacy two-state FSM. j&k in OFF goes ON, and j&k in ON goes OFF, so the channel toggles.
- out[i] = (state[i] != OFF). It is purely a state decode with no combinational path from j or k.
- rise[i] / fall[i] are registered from the next-state decode: rise <= next_on & ~cur_on, fall <= ~next_on & cur_on. Each pulse therefore coincides with the first cycle of the new out value.
- active_cnt and all_off are combinational from the current out vector and use no wrap arithmetic; the maximum value is CHANNELS.
- Channels are fully independent; there is no shared state except reset.

## Timing
- Reset: at a posedge with reset=1, every channel goes OFF, cnt=0, rise=0 and fall=0. After that edge: out=0, active_cnt=0, all_off=1.
- Reset has priority over j and k. Reset mid-HOLD or in ON forces OFF at the next edge, produces no fall pulse, and clears cnt.
- j sampled high at edge t in OFF: out=1 and rise=1 from edge t; rise drops at edge t+1.
- Minimum out-high time is DWELL+1 cycles. For DWELL>0, HOLD spans edges t..t+DWELL-1 and ON is entered at edge t+DWELL. The earliest honoured k is at edge t+DWELL+1, so out=0 from then.
- k=1 held through HOLD does nothing until ON; it is then honoured at the first edge in ON.
- k sampled high at edge u in ON: out=0 and fall=1 from edge u for one cycle.
- The first rising edge after reset release may move channels; there is no extra latency.
- rise/fall never assert in the same cycle for the same channel.

## Test plan
- Reset: hold reset 2 cycles with j=4'hF.
  - Required: out=0, rise=fall=0, active_cnt=0, all_off=1. No rise on the reset-release cycle unless j=1 at that edge.
- Dwell (DWELL=3, MODE=0): 1-cycle pulse on j[0], k[0] held 1 throughout.
  - Required: out[0]=1 for exactly 4 cycles; rise[0] one cycle at the start; fall[0] one cycle at the end.
- Toggle (DWELL=3, MODE=0): j[1]=k[1]=1 continuously.
  - Required: out[1] repeats high 4 cycles, low 1 cycle (period 5), with rise and fall pulses each period.
- Set-priority (second instance, DWELL=0, MODE=1): j=k=1 held on ch2.
  - Required: out[2] goes 1 and stays 1. Dropping j with k=1 gives out[2]=0 next edge.
- Aggregate: j=4'hF for one cycle.
  - Required: active_cnt=4 and all_off=0 next cycle. Releasing channels one at a time after dwell decrements the count 3,2,1,0; all_off=1 at 0.
- Reset mid-operation: reset asserted while ch0 is in HOLD (cnt=1).
  - Required: out[0]=0 next cycle, fall[0]=0. A subsequent j gives a full 4-cycle dwell again.
